constant_addition_sequencer: RTL and testbench

//  Upstream stage of the Ascon round datapath. Holds the 320-bit permutation state and a round

---
 rtl/constant_addition_sequencer.sv | 131 +++++++++++++
 tb/tb_constant_addition_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/constant_addition_sequencer.sv
// Ascon round sequencer: holds the 320-bit state and the round counter, and XORs the round
// constant into word x2 ahead of the external substitution and diffusion layers.
module constant_addition_sequencer #(
    parameter int unsigned MAX_ROUNDS = 12,
    parameter int unsigned RC_WORD    = 2
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    input  logic [319:0] round_result_i,
    output logic [319:0] add_o,
    output logic [3:0]   round_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [319:0] state_o
);

    localparam int unsigned WORD_W    = 64;
    localparam int unsigned NUM_WORDS = 5;
    localparam int unsigned STATE_W   = WORD_W * NUM_WORDS;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned RC_W      = 8;
    // x0 occupies the most significant word, so word k starts at bit (4-k)*64
    localparam int unsigned RC_LSB    = (NUM_WORDS - 1 - RC_WORD) * WORD_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [STATE_W-1:0] out_q, out_d;
    logic [CNT_W-1:0]   round_q, round_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   n_c;
    logic [CNT_W-1:0]   i0_c;
    logic               last_c;
    logic [RC_W-1:0]    rc_c;
    logic [STATE_W-1:0] add_c;

    // Round count clamp and the table index the run starts from
    always_comb begin
        n_c = rounds_i;
        if (rounds_i > CNT_W'(MAX_ROUNDS)) begin
            n_c = CNT_W'(MAX_ROUNDS);
        end
        i0_c = CNT_W'(MAX_ROUNDS) - n_c;
    end

    assign last_c = (round_q == CNT_W'(MAX_ROUNDS - 1));
    assign rc_c   = {4'hF - round_q, round_q};

    // Constant addition only applies while rounds are executing
    always_comb begin
        add_c = state_q;
        if (fsm_q == S_RUN) begin
            add_c[RC_LSB +: RC_W] = state_q[RC_LSB +: RC_W] ^ rc_c;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        out_d   = out_q;
        round_d = round_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (fsm_q)
            S_IDLE, S_DONE: begin
                fsm_d = S_IDLE;
                if (start_i) begin
                    state_d = state_i;
                    if (n_c != '0) begin
                        fsm_d   = S_RUN;
                        round_d = i0_c;
                        busy_d  = 1'b1;
                    end else begin
                        fsm_d  = S_DONE;
                        out_d  = state_i;
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                state_d = round_result_i;
                if (last_c) begin
                    fsm_d  = S_DONE;
                    out_d  = round_result_i;
                    done_d = 1'b1;
                end else begin
                    round_d = round_q + CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            out_q   <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            out_q   <= out_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign add_o   = add_c;
    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign state_o = out_q;

endmodule

// File: tb/tb_constant_addition_sequencer.sv
// Directed and randomized checks of the Ascon round sequencer against a permutation model
// built from the constant table and a bitsliced reference round.
module tb_constant_addition_sequencer;

    logic         clock_i;
    logic         reset_i;
    logic         start_i;
    logic [3:0]   rounds_i;
    logic [319:0] state_i;
    logic [319:0] round_result_i;
    logic [319:0] add_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;
    logic [319:0] state_o;

    bit loop_real;
    int n_checks;
    int n_pass;

    localparam logic [7:0] RC_TABLE [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    constant_addition_sequencer dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .rounds_i       (rounds_i),
        .state_i        (state_i),
        .round_result_i (round_result_i),
        .add_o          (add_o),
        .round_o        (round_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .state_o        (state_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Substitution then linear diffusion, x0 in the top word
    function automatic logic [319:0] ascon_round(input logic [319:0] s);
        logic [63:0] x [5];
        logic [63:0] t [5];
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
        for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
        for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
        x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
        x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
        x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
        x[2] ^= ror(x[2], 1)  ^ ror(x[2], 6);
        x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
        x[4] ^= ror(x[4], 7)  ^ ror(x[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] add_const(input logic [319:0] s, input int idx);
        logic [319:0] r;
        r = s;
        r[135:128] = r[135:128] ^ RC_TABLE[idx];
        return r;
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input int n, input bit real_rnd);
        logic [319:0] r;
        r = s;
        for (int k = 12 - n; k < 12; k++) begin
            r = add_const(r, k);
            if (real_rnd) r = ascon_round(r);
        end
        return r;
    endfunction

    assign round_result_i = loop_real ? ascon_round(add_o) : add_o;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Start a permutation; optionally pulse a stray start at round index restart_at
    task automatic run_perm(input logic [319:0] s_in, input logic [3:0] r_in, input bit real_rnd,
                            input int restart_at, input bit go_idle);
        int n;
        logic [319:0] ms;
        logic [319:0] exp_add;
        logic [319:0] gold;
        n    = (r_in > 4'd12) ? 12 : int'(r_in);
        gold = perm(s_in, n, real_rnd);
        loop_real = real_rnd;
        state_i  = s_in;
        rounds_i = r_in;
        start_i  = 1'b1;
        tick();
        start_i = 1'b0;
        ms = s_in;
        for (int r = 0; r < n; r++) begin
            exp_add = add_const(ms, 12 - n + r);
            check("busy_run", 320'(busy_o), 320'(1));
            check("done_run", 320'(done_o), 320'(0));
            check("round_idx", 320'(round_o), 320'(12 - n + r));
            check("add_o", add_o, exp_add);
            if (r == restart_at) begin
                state_i  = ~s_in;
                rounds_i = 4'd6;
                start_i  = 1'b1;
            end
            ms = real_rnd ? ascon_round(exp_add) : exp_add;
            tick();
            start_i = 1'b0;
        end
        check("done_pulse", 320'(done_o), 320'(1));
        check("busy_done", 320'(busy_o), 320'(0));
        check("state_o", state_o, gold);
        check("add_done", add_o, gold);
        if (n > 0) check("round_last", 320'(round_o), 320'(11));
        if (go_idle) begin
            tick();
            check("done_clear", 320'(done_o), 320'(0));
            check("busy_idle", 320'(busy_o), 320'(0));
            check("state_hold", state_o, gold);
        end
    endtask

    initial begin
        logic [319:0] iv_state;
        logic [319:0] rs;
        n_checks  = 0;
        n_pass    = 0;
        loop_real = 1'b0;
        reset_i   = 1'b1;
        start_i   = 1'b0;
        rounds_i  = 4'd0;
        state_i   = '0;
        #3;
        check("rst_busy", 320'(busy_o), 320'(0));
        check("rst_done", 320'(done_o), 320'(0));
        check("rst_round", 320'(round_o), 320'(0));
        check("rst_add", add_o, 320'(0));
        check("rst_state", state_o, 320'(0));
        #14 reset_i = 1'b0;
        tick();

        // 1: identity rounds, all constants cancel
        run_perm(320'(0), 4'd12, 1'b0, -1, 1'b1);
        check("t1_zero", state_o, 320'(0));

        // 2: six rounds leave 0x11 in x2
        run_perm(320'(0), 4'd6, 1'b0, -1, 1'b1);
        check("t2_x2", 320'(state_o[191:128]), 320'(64'h11));
        check("t2_rest", {state_o[319:192], 64'h0, state_o[127:0]}, 320'(0));

        // 3: real rounds, clamping and zero-round runs
        iv_state = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                    64'h0011223344556677, 64'h8899aabbccddeeff};
        run_perm(iv_state, 4'd8, 1'b1, -1, 1'b1);
        run_perm(iv_state, 4'd15, 1'b1, -1, 1'b1);
        run_perm(iv_state, 4'd0, 1'b0, -1, 1'b1);

        // 4: stray start mid-run is ignored
        run_perm(320'(0), 4'd12, 1'b0, 3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_no_extra_done", 320'(done_o), 320'(0));
            check("t4_idle", 320'(busy_o), 320'(0));
        end

        // 5: asynchronous reset in round 5
        loop_real = 1'b0;
        state_i   = iv_state;
        rounds_i  = 4'd12;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        check("t5_round5", 320'(round_o), 320'(5));
        #2 reset_i = 1'b1;
        #1;
        check("t5_busy", 320'(busy_o), 320'(0));
        check("t5_done", 320'(done_o), 320'(0));
        check("t5_round", 320'(round_o), 320'(0));
        check("t5_add", add_o, 320'(0));
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t5_no_done", 320'(done_o), 320'(0));
        end
        run_perm(320'(0), 4'd12, 1'b0, -1, 1'b1);
        check("t5_rerun", state_o, 320'(0));

        // 6: back-to-back starts in the done cycle
        run_perm(iv_state, 4'd8, 1'b1, -1, 1'b0);
        run_perm(~iv_state, 4'd12, 1'b0, -1, 1'b0);
        run_perm(iv_state, 4'd0, 1'b0, -1, 1'b0);
        run_perm(iv_state, 4'd6, 1'b1, -1, 1'b1);

        // Randomized runs
        for (int t = 0; t < 10; t++) begin
            for (int w = 0; w < 10; w++) rs[32*w +: 32] = $urandom;
            run_perm(rs, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     (t % 3 == 0) ? int'($urandom_range(0, 5)) : -1, 1'($urandom_range(0, 1)));
        end
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
